// File: rtl/wg_pkg.sv
// Shared types and default widths for the register-file port arbiter.
package wg_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int  NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic [IW:0] cand;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!any && req[cand[IW-1:0]]) begin
        any                 = 1'b1;
        onehot[cand[IW-1:0]] = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_arb.sv
// Round-robin arbiter sharing one register-file port among NREQ requesters.
//   state   | meaning
//   IDLE    | waiting; samples winner and its we/addr/wdata
//   ACCESS  | gnt pulse, address/data driven, write strobe for writes
//   RD_WAIT | register file produces read data; captured at end of cycle
//   RD_DONE | rvalid pulse for the winner, rdata valid
module reg_arb
  import wg_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic [AW-1:0]      reg_addr_o,
  output logic [DW-1:0]      reg_data_o,
  output logic               reg_wr_en_o,
  input  logic [DW-1:0]      reg_data_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state;
  logic [IW-1:0]   last_gnt;
  logic            we_q;
  logic            pick_any;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_i),
    .last   (last_gnt),
    .any    (pick_any),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // last_gnt doubles as the winner index for the access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_o       <= '0;
      rvalid_o    <= '0;
      reg_wr_en_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_data_o  <= '0;
      rdata_o     <= '0;
      last_gnt    <= IW'(NREQ-1);
      we_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_o       <= pick_oh;
            last_gnt    <= pick_idx;
            we_q        <= we_i[pick_idx];
            reg_wr_en_o <= we_i[pick_idx];
            reg_addr_o  <= addr_i[int'(pick_idx)*AW +: AW];
            reg_data_o  <= wdata_i[int'(pick_idx)*DW +: DW];
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          gnt_o       <= '0;
          reg_wr_en_o <= 1'b0;
          state       <= we_q ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          rdata_o  <= reg_data_i;
          rvalid_o <= NREQ'(1) << last_gnt;
          state    <= RD_DONE;
        end
        RD_DONE: begin
          rvalid_o <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arb.sv
// Directed bench for reg_arb with two requesters and a registered register-file model.
module tb_reg_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_wr_en;
  logic [7:0]  reg_rdata = '0;
  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  reg_arb #(.NREQ(2), .AW(8), .DW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .reg_addr_o  (reg_addr),
    .reg_data_o  (reg_data),
    .reg_wr_en_o (reg_wr_en),
    .reg_data_i  (reg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    reg_rdata <= mem[reg_addr];
    if (reg_wr_en) mem[reg_addr] <= reg_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] alt_exp [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_wr_en", 32'(reg_wr_en), 32'h0);
    check("rst_addr", 32'(reg_addr), 32'h0);
    check("rst_data", 32'(reg_data), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    rst_n = 1'b1;
    tick();

    // single write from requester 0
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h05; wdata[7:0] = 8'hA5;
    tick();
    check("wr_gnt", 32'(gnt), 32'h1);
    check("wr_en", 32'(reg_wr_en), 32'h1);
    check("wr_addr", 32'(reg_addr), 32'h05);
    check("wr_data", 32'(reg_data), 32'hA5);
    req = 2'b00;
    tick();
    check("wr_gnt_end", 32'(gnt), 32'h0);
    check("wr_en_end", 32'(reg_wr_en), 32'h0);
    check("wr_addr_hold", 32'(reg_addr), 32'h05);

    // single read from requester 0
    req = 2'b01; we = 2'b00;
    tick();
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_wr_en", 32'(reg_wr_en), 32'h0);
    req = 2'b00;
    tick();
    check("rd_wait_rvalid", 32'(rvalid), 32'h0);
    tick();
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_rdata", 32'(rdata), 32'hA5);
    tick();
    check("rd_rvalid_end", 32'(rvalid), 32'h0);
    check("rd_rdata_hold", 32'(rdata), 32'hA5);

    // both requesters writing continuously; last winner was 0
    req = 2'b11; we = 2'b11;
    addr = {8'h20, 8'h10}; wdata = {8'h22, 8'h11};
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("alt_gnt_%0d", i), 32'(gnt), 32'(alt_exp[i]));
    end
    req = 2'b00;
    check("alt_mem20", 32'(mem[8'h20]), 32'h22);
    check("alt_mem10", 32'(mem[8'h10]), 32'h11);

    // requester 1 read in flight, requester 0 write waits
    req = 2'b10; we = 2'b00; addr[15:8] = 8'h20;
    tick();
    check("inf_gnt1", 32'(gnt), 32'h2);
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h30; wdata[7:0] = 8'h33;
    tick();
    check("inf_wait_gnt", 32'(gnt), 32'h0);
    tick();
    check("inf_rvalid", 32'(rvalid), 32'h2);
    check("inf_rdata", 32'(rdata), 32'h22);
    check("inf_done_gnt", 32'(gnt), 32'h0);
    tick();
    check("inf_idle_gnt", 32'(gnt), 32'h0);
    check("inf_idle_rvalid", 32'(rvalid), 32'h0);
    tick();
    check("inf_gnt0", 32'(gnt), 32'h1);
    check("inf_wr_addr", 32'(reg_addr), 32'h30);
    req = 2'b00;
    tick();

    // requester 1 drops its request right after sampling
    req = 2'b10; we = 2'b10; addr[15:8] = 8'h40; wdata[15:8] = 8'h44;
    tick();
    req = 2'b00; we = 2'b00; addr[15:8] = 8'hFF; wdata[15:8] = 8'h00;
    check("drop_gnt", 32'(gnt), 32'h2);
    check("drop_addr", 32'(reg_addr), 32'h40);
    check("drop_data", 32'(reg_data), 32'h44);
    check("drop_wr_en", 32'(reg_wr_en), 32'h1);
    tick();
    check("drop_mem40", 32'(mem[8'h40]), 32'h44);

    // reset while a read from requester 1 sits in RD_WAIT
    req = 2'b10; we = 2'b00; addr[15:8] = 8'h20;
    tick();
    check("rst_rd_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_rvalid", 32'(rvalid), 32'h0);
    check("arst_addr", 32'(reg_addr), 32'h0);
    check("arst_rdata", 32'(rdata), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("arst_no_rvalid_%0d", i), 32'(rvalid), 32'h0);
    end
    req = 2'b11; we = 2'b11;
    addr = {8'h60, 8'h50}; wdata = {8'h66, 8'h55};
    tick();
    check("arst_next_gnt", 32'(gnt), 32'h1);
    check("arst_next_addr", 32'(reg_addr), 32'h50);
    req = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
